// File: rtl/conv2d_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_pkg
// Description : Shared types and helpers for the conv2d frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
package conv2d_pkg;

    typedef enum logic [2:0] {IDLE, FLUSH, STREAM, DRAIN, DONE} frame_state_t;

    function automatic int win_per_frame(input int n, input int k);
        return (n - k + 1) * (n - k + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv2d_frame_ctrl_credit.sv
`default_nettype none
// ============================================================================
// Module      : credit_counter
// Description : Downstream window-slot credit pool, saturating at CREDITS.
// Revision    : 1.0 - initial release
// ============================================================================
module credit_counter #(
    parameter int CREDITS = 4
) (
    input  logic                           clk,
    input  logic                           clear,
    input  logic                           i_reserve,
    input  logic                           i_return,
    output logic [$clog2(CREDITS+1)-1:0]   o_avail,
    output logic                           o_overflow
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] C_FULL = CW'(CREDITS);

    logic [CW-1:0] r_cnt;

    // A return with nothing outstanding is a protocol error; the pool holds.
    assign o_overflow = i_return && !i_reserve && (r_cnt == C_FULL);
    assign o_avail    = r_cnt;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_cnt <= C_FULL;
        end else if (i_reserve && !i_return) begin
            r_cnt <= r_cnt - 1'b1;
        end else if (i_return && !i_reserve && (r_cnt != C_FULL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv2d_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_frame_ctrl
// Description : Frame sequencer and credit throttle in front of the window buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_frame_ctrl #(
    parameter int N_IMAGE  = 8,
    parameter int K_KERNEL = 3,
    parameter int BWD      = 8,
    parameter int CREDITS  = 4
) (
    input  logic           clk,
    input  logic           clear,
    input  logic           i_start,
    input  logic [7:0]     i_num_frames,
    input  logic [BWD-1:0] s_data,
    input  logic           s_valid,
    output logic           s_ready,
    output logic [BWD-1:0] o_buf_data,
    output logic           o_buf_valid,
    output logic           o_buf_clear,
    input  logic           i_win_valid,
    input  logic           i_win_end,
    input  logic           i_credit_ret,
    output logic           o_busy,
    output logic           o_frame_done,
    output logic           o_done,
    output logic           o_err
);
    import conv2d_pkg::*;

    localparam int PW  = (N_IMAGE > 1) ? $clog2(N_IMAGE) : 1;
    localparam int CW  = $clog2(CREDITS + 1);
    localparam int WW  = $clog2(N_IMAGE * N_IMAGE + 1);
    localparam int WPF = win_per_frame(N_IMAGE, K_KERNEL);

    localparam logic [PW-1:0] C_LAST = PW'(N_IMAGE - 1);
    localparam logic [PW-1:0] C_KM1  = PW'(K_KERNEL - 1);
    localparam logic [WW-1:0] C_WPF  = WW'(WPF);

    frame_state_t   r_state;
    frame_state_t   w_next;
    logic [7:0]     r_frames_left;
    logic [PW-1:0]  r_row;
    logic [PW-1:0]  r_col;
    logic [WW-1:0]  r_win_cnt;
    logic [BWD-1:0] r_buf_data;
    logic           r_buf_valid;
    logic           r_err;

    logic           w_completes;
    logic           w_hs;
    logic           w_last_px;
    logic [CW-1:0]  w_avail;
    logic           w_overflow;
    logic           w_win_state;
    logic           w_cnt_bad;
    logic           w_stray;
    logic           w_err_clr;

    credit_counter #(.CREDITS(CREDITS)) u_credit (
        .clk        (clk),
        .clear      (clear),
        .i_reserve  (w_hs && w_completes),
        .i_return   (i_credit_ret),
        .o_avail    (w_avail),
        .o_overflow (w_overflow)
    );

    // Only window-completing pixels consume a slot, so only they wait on credit.
    assign w_completes = (r_col >= C_KM1) && (r_row >= C_KM1);
    assign s_ready     = (r_state == STREAM) && (!w_completes || (w_avail != '0));
    assign w_hs        = s_valid && s_ready;
    assign w_last_px   = (r_row == C_LAST) && (r_col == C_LAST);

    assign w_win_state = (r_state == STREAM) || (r_state == DRAIN);
    assign w_cnt_bad   = i_win_end && w_win_state &&
                         ((r_win_cnt + WW'(i_win_valid)) != C_WPF);
    assign w_stray     = !w_win_state && (i_win_valid || i_win_end);
    assign w_err_clr   = (r_state == IDLE) && i_start;

    assign o_buf_data  = r_buf_data;
    assign o_buf_valid = r_buf_valid;
    assign o_busy      = (r_state != IDLE);
    assign o_err       = r_err;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_buf_clear  = 1'b0;
        o_frame_done = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            IDLE:   if (i_start) w_next = (i_num_frames != 8'd0) ? FLUSH : DONE;
            FLUSH: begin
                o_buf_clear = 1'b1;
                w_next      = STREAM;
            end
            STREAM: if (w_hs && w_last_px) w_next = DRAIN;
            DRAIN: begin
                if (i_win_end) begin
                    o_frame_done = 1'b1;
                    w_next       = (r_frames_left != 8'd1) ? FLUSH : DONE;
                end
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_frames_left <= 8'd0;
            r_row         <= '0;
            r_col         <= '0;
            r_win_cnt     <= '0;
            r_buf_data    <= '0;
            r_buf_valid   <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_buf_valid <= w_hs;
            if (w_hs) begin
                r_buf_data <= s_data;
            end
            r_err <= (r_err && !w_err_clr) || w_cnt_bad || w_stray || w_overflow;
            case (r_state)
                IDLE: if (i_start) r_frames_left <= i_num_frames;
                FLUSH: begin
                    r_row     <= '0;
                    r_col     <= '0;
                    r_win_cnt <= '0;
                end
                STREAM: begin
                    if (i_win_valid) r_win_cnt <= r_win_cnt + 1'b1;
                    if (w_hs) begin
                        if (r_col == C_LAST) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (i_win_valid) r_win_cnt <= r_win_cnt + 1'b1;
                    if (i_win_end) r_frames_left <= r_frames_left - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2d_frame_ctrl
// Description : Scoreboard bench with a behavioural window-buffer/credit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_frame_ctrl;
    localparam int N     = 8;
    localparam int K     = 3;
    localparam int BWD   = 8;
    localparam int CRED  = 4;
    localparam int C_WPF = (N - K + 1) * (N - K + 1);

    logic           clk = 1'b0;
    logic           clear;
    logic           i_start;
    logic [7:0]     i_num_frames;
    logic [BWD-1:0] s_data;
    logic           s_valid;
    logic           s_ready;
    logic [BWD-1:0] o_buf_data;
    logic           o_buf_valid;
    logic           o_buf_clear;
    logic           i_win_valid;
    logic           i_win_end;
    logic           i_credit_ret;
    logic           o_busy;
    logic           o_frame_done;
    logic           o_done;
    logic           o_err;

    conv2d_frame_ctrl #(.N_IMAGE(N), .K_KERNEL(K), .BWD(BWD), .CREDITS(CRED)) dut (
        .clk          (clk),
        .clear        (clear),
        .i_start      (i_start),
        .i_num_frames (i_num_frames),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .o_buf_data   (o_buf_data),
        .o_buf_valid  (o_buf_valid),
        .o_buf_clear  (o_buf_clear),
        .i_win_valid  (i_win_valid),
        .i_win_end    (i_win_end),
        .i_credit_ret (i_credit_ret),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Stimulus controls and behavioural window buffer.
    logic src_on = 1'b0, auto_ret = 1'b0, man_ret = 1'b0, man_win = 1'b0;
    int   wb_row = 0, wb_col = 0, wb_cnt = 0;
    logic win_pend = 1'b0, end_pend = 1'b0;
    logic [2:0] ret_pipe = 3'b000;

    always @(posedge clk) begin
        #2;
        if (clear) begin
            wb_row = 0; wb_col = 0; wb_cnt = 0;
            win_pend = 1'b0; end_pend = 1'b0; ret_pipe = 3'b000;
            i_win_valid = 1'b0; i_win_end = 1'b0; i_credit_ret = 1'b0;
        end else begin
            i_win_valid  = win_pend | man_win;
            i_win_end    = end_pend;
            ret_pipe     = {ret_pipe[1:0], win_pend & auto_ret};
            i_credit_ret = ret_pipe[2] | man_ret;
            win_pend = 1'b0;
            end_pend = 1'b0;
            if (o_buf_clear) begin
                wb_row = 0; wb_col = 0; wb_cnt = 0;
            end else if (o_buf_valid) begin
                if (wb_row >= K - 1 && wb_col >= K - 1) begin
                    wb_cnt++;
                    win_pend = 1'b1;
                    end_pend = (wb_cnt == C_WPF);
                end
                if (wb_col == N - 1) begin
                    wb_col = 0;
                    wb_row++;
                end else begin
                    wb_col++;
                end
            end
        end
        s_valid = src_on;
        s_data  = BWD'($urandom_range(0, 255));
    end

    // Scoreboard and event counters, sampled mid-cycle.
    logic [BWD-1:0] sb[$];
    int   n_hs, n_clr, n_win, n_fd, n_done, cyc, fd_cyc, done_cyc;
    logic prev_done, busy_at_done, busy_after;

    always @(negedge clk) begin
        cyc++;
        if (clear) begin
            sb.delete();
        end else begin
            if (o_buf_valid) begin
                if (sb.size() == 0) chk("pix_unexpected", 32'd1, 32'd0);
                else                chk("pix_data", 32'(o_buf_data), 32'(sb.pop_front()));
            end
            if (s_valid && s_ready) begin
                sb.push_back(s_data);
                n_hs++;
            end
            if (o_buf_clear) n_clr++;
            if (i_win_valid) n_win++;
            if (o_frame_done) begin n_fd++; fd_cyc = cyc; end
            if (prev_done) busy_after = o_busy;
            if (o_done) begin n_done++; done_cyc = cyc; busy_at_done = o_busy; end
            prev_done = o_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_counts();
        n_hs = 0; n_clr = 0; n_win = 0; n_fd = 0; n_done = 0;
        fd_cyc = 0; done_cyc = 0; prev_done = 1'b0; busy_at_done = 1'b0; busy_after = 1'b1;
    endtask

    task automatic start(input int frames);
        tick();
        i_num_frames = 8'(frames);
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_done != 0) break;
            smp();
        end
        chk("done_seen", 32'(n_done != 0), 32'd1);
        repeat (8) smp();
    endtask

    task automatic wait_hs(input int target);
        for (int i = 0; i < 400; i++) begin
            if (n_hs >= target) break;
            smp();
        end
        chk("hs_reached", 32'(n_hs >= target), 32'd1);
    endtask

    task automatic do_clear();
        tick();
        src_on = 1'b0; auto_ret = 1'b0; man_ret = 1'b0; man_win = 1'b0;
        clear  = 1'b1;
        tick();
        tick();
        clear  = 1'b0;
        reset_counts();
    endtask

    initial begin
        clear = 1'b1; i_start = 1'b0; i_num_frames = 8'd0;
        s_valid = 1'b0; s_data = '0;
        i_win_valid = 1'b0; i_win_end = 1'b0; i_credit_ret = 1'b0;
        cyc = 0;
        reset_counts();
        repeat (3) smp();
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_buf_valid", 32'(o_buf_valid), 0);
        chk("rst_buf_data", 32'(o_buf_data), 0);
        chk("rst_buf_clear", 32'(o_buf_clear), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_frame_done", 32'(o_frame_done), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_err", 32'(o_err), 0);
        tick();
        clear = 1'b0;

        // Single frame with credits returned two cycles after each window.
        reset_counts();
        auto_ret = 1'b1; src_on = 1'b1;
        start(1);
        smp();
        chk("sf_flush_clr", 32'(o_buf_clear), 1);
        chk("sf_flush_rdy", 32'(s_ready), 0);
        chk("sf_busy", 32'(o_busy), 1);
        smp();
        chk("sf_first_rdy", 32'(s_ready), 1);
        wait_done(2000);
        chk("sf_pixels", 32'(n_hs), 64);
        chk("sf_windows", 32'(n_win), C_WPF);
        chk("sf_frame_done", 32'(n_fd), 1);
        chk("sf_done", 32'(n_done), 1);
        chk("sf_clr", 32'(n_clr), 1);
        chk("sf_err", 32'(o_err), 0);
        chk("sf_fd_to_done", 32'(done_cyc - fd_cyc), 1);
        chk("sf_busy_at_done", 32'(busy_at_done), 1);
        chk("sf_busy_after", 32'(busy_after), 0);
        src_on = 1'b0;

        // Credit stall: no returns, stall at the fifth window pixel (row 2, col 6).
        reset_counts();
        auto_ret = 1'b0; src_on = 1'b1;
        start(1);
        wait_hs(22);
        repeat (4) smp();
        chk("st_pixels", 32'(n_hs), 22);
        chk("st_ready_low", 32'(s_ready), 0);
        tick();
        man_ret = 1'b1;
        smp();
        chk("st_ret_cycle", 32'(s_ready), 0);
        tick();
        man_ret = 1'b0;
        smp();
        chk("st_resume", 32'(s_ready), 1);
        smp();
        chk("st_restall", 32'(s_ready), 0);
        chk("st_pixels2", 32'(n_hs), 23);
        do_clear();

        // Three frames back to back.
        auto_ret = 1'b1; src_on = 1'b1;
        start(3);
        wait_done(5000);
        chk("mf_clr", 32'(n_clr), 3);
        chk("mf_pixels", 32'(n_hs), 192);
        chk("mf_windows", 32'(n_win), 3 * C_WPF);
        chk("mf_frame_done", 32'(n_fd), 3);
        chk("mf_done", 32'(n_done), 1);
        chk("mf_err", 32'(o_err), 0);
        chk("mf_sb_empty", 32'(sb.size()), 0);

        // Mid-frame reset, then a clean frame.
        reset_counts();
        start(1);
        wait_hs(20);
        tick();
        clear = 1'b1;
        #2;
        chk("mr_s_ready", 32'(s_ready), 0);
        chk("mr_buf_valid", 32'(o_buf_valid), 0);
        chk("mr_buf_data", 32'(o_buf_data), 0);
        chk("mr_busy", 32'(o_busy), 0);
        chk("mr_credits", 32'(dut.u_credit.r_cnt), CRED);
        tick();
        clear = 1'b0;
        reset_counts();
        start(1);
        wait_done(2000);
        chk("mr_pixels", 32'(n_hs), 64);
        chk("mr_windows", 32'(n_win), C_WPF);
        chk("mr_frame_done", 32'(n_fd), 1);
        chk("mr_err", 32'(o_err), 0);
        src_on = 1'b0;

        // Error flag: credit overflow, clear by start, stray window, clear again.
        tick();
        man_ret = 1'b1;
        tick();
        man_ret = 1'b0;
        smp();
        chk("er_overflow", 32'(o_err), 1);
        repeat (5) smp();
        chk("er_sticky", 32'(o_err), 1);
        reset_counts();
        start(0);
        smp();
        chk("zf_done", 32'(o_done), 1);
        chk("zf_busy", 32'(o_busy), 1);
        chk("zf_err_cleared", 32'(o_err), 0);
        smp();
        chk("zf_done_end", 32'(o_done), 0);
        chk("zf_idle", 32'(o_busy), 0);
        chk("zf_clr", 32'(n_clr), 0);
        chk("zf_pixels", 32'(n_hs), 0);
        chk("zf_done_cnt", 32'(n_done), 1);
        tick();
        man_win = 1'b1;
        tick();
        man_win = 1'b0;
        smp();
        chk("er_stray_win", 32'(o_err), 1);
        start(0);
        smp();
        chk("er_start_clears", 32'(o_err), 0);
        repeat (3) smp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/conv2d_frame_ctrl.md
# conv2d_frame_ctrl

Frame sequencer for the conv2d window buffer. Sits between the pixel source and the window buffer. It runs a programmed number of frames: it pulses the buffer's clear before each frame, admits exactly `N_IMAGE*N_IMAGE` pixels per frame, and throttles the source with credits so downstream window storage never overflows. It also checks that each frame produces the expected window count and that window-end arrives once.

## Interface
- `N_IMAGE`, 8: image side length in pixels.
- `K_KERNEL`, 3: kernel side length; must match the window buffer.
- `BWD`, 8: pixel width.
- `CREDITS`, 4: downstream window slots; range 1..255.

- `clk`  in  1  clock.
- `clear`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  one-cycle start pulse; ignored unless in IDLE.
- `i_num_frames`  in  8  frames to run; sampled on an accepted `i_start`; 0 means go straight to DONE.
- `s_data`  in  BWD  source pixel.
- `s_valid`  in  1  source pixel valid.
- `s_ready`  out  1  controller accepts pixel.
- `o_buf_data`  out  BWD  pixel to window buffer.
- `o_buf_valid`  out  1  pixel valid to window buffer.
- `o_buf_clear`  out  1  synchronous clear to window buffer.
- `i_win_valid`  in  1  window buffer output valid.
- `i_win_end`  in  1  window buffer last-window flag.
- `i_credit_ret`  in  1  downstream freed one window slot.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_frame_done`  out  1  one-cycle pulse per completed frame.
- `o_done`  out  1  one-cycle pulse when all frames are complete.
- `o_err`  out  1  sticky error flag; cleared only by `clear` or an accepted `i_start`.

## Operation
FSM states and transitions:
- **IDLE**
  - Accepted `i_start` latches `i_num_frames` into `frames_left` and clears `o_err`.
  - Goes to FLUSH if `frames_left` ≠ 0, else DONE.
- **FLUSH**: `o_buf_clear`=1 for exactly one cycle; resets pixel row/col counters and `win_cnt`; goes to STREAM.
- **STREAM**
  - `s_ready` = pixel still owed AND (the pixel does not complete a window OR `credit_cnt` > 0).
  - A pixel completes a window when its col ≥ K_KERNEL-1 and its row ≥ K_KERNEL-1.
  - On a handshake (`s_valid && s_ready`):
    - the pixel is registered to `o_buf_data`/`o_buf_valid`;
    - col/row advance, col wrapping at N_IMAGE-1;
    - one credit is reserved if the pixel completes a window.
  - After pixel `N_IMAGE*N_IMAGE` is accepted, go to DRAIN.
- **DRAIN**
  - `s_ready`=0; wait for `i_win_end`.
  - On `i_win_end`: `o_frame_done` pulses and `frames_left` decrements.
  - Go to FLUSH if frames remain, else DONE.
- **DONE**: `o_done` pulses for one cycle; go to IDLE.

Counting and checking:
- `win_cnt` counts `i_win_valid` in STREAM and DRAIN.
- At `i_win_end`, `win_cnt` including that window must equal `(N_IMAGE-K_KERNEL+1)^2`; otherwise set `o_err`.
- `i_win_valid` or `i_win_end` seen in IDLE, FLUSH or DONE sets `o_err`.

Credits:
- `credit_cnt` width is `$clog2(CREDITS+1)`; it resets to CREDITS and is never reloaded by FLUSH.
- Reserve and return in the same cycle leaves `credit_cnt` unchanged.
- A return while `credit_cnt`==CREDITS saturates at CREDITS and sets `o_err`.
- `credit_cnt` never goes below 0; the gating on `s_ready` guarantees this.

Reset:
- `clear` asserted at any time, including mid-frame, immediately forces:
  - IDLE, all outputs 0, `credit_cnt`=CREDITS, counters 0.
- Partially streamed frames are dropped. The next frame's FLUSH clears the buffer.

## Timing
- Reset values:
  - `s_ready`=0, `o_buf_valid`=0, `o_buf_data`=0, `o_buf_clear`=0.
  - `o_busy`=0, `o_frame_done`=0, `o_done`=0, `o_err`=0.
- `s_ready` is combinational from registered state and `credit_cnt` only; it never depends on `s_valid`.
- Pixel handshake at edge t gives `o_buf_valid`=1 in cycle t+1.
- `i_start` accepted at edge t: FLUSH in cycle t+1, and the first `s_ready` can be 1 in cycle t+2.
- Between frames: the `i_win_end` cycle, then one FLUSH cycle, then STREAM resumes.
- With continuous `s_valid` and ample credits, throughput is 1 pixel/cycle.
- The `o_busy` 1→0 transition coincides with the cycle after `o_done`.
- `o_frame_done` for the last frame precedes `o_done` by one cycle.

## Structure
- Shared package `conv2d_pkg` holds:
  - `typedef enum logic [2:0] {IDLE, FLUSH, STREAM, DRAIN, DONE} frame_state_t`;
  - function `win_per_frame(N,K)` returning `(N-K+1)^2`.
- One natural sub-module, `credit_counter`:
  - ports: `clk`, `clear`, reserve, return, `avail`, `overflow`;
  - parameterised by CREDITS.

## Test plan
With N_IMAGE=8, K_KERNEL=3, CREDITS=4:
- **Single frame**: `i_num_frames`=1, source always valid, credit returned 2 cycles after each window → 64 pixels accepted, 36 windows, one `o_frame_done`, then `o_done`, `o_err`=0.
- **Credit stall**: `i_credit_ret` held 0 → `s_ready` drops when the source offers the 5th window-completing pixel (row 2, col 6). It resumes one cycle after a single `i_credit_ret` pulse.
- **Multi-frame**: `i_num_frames`=3 → `o_buf_clear` pulses exactly 3 times, 192 pixels accepted, 108 windows, 3 `o_frame_done`, 1 `o_done`.
- **Mid-frame reset**: `clear` asserted after 20 pixels → all outputs 0 the same cycle, `credit_cnt`=4. A following 1-frame run completes cleanly with 36 windows.
- **Error checks**:
  - extra `i_credit_ret` at full credit → `o_err`=1 and it stays set;
  - an injected spurious `i_win_valid` in IDLE also sets `o_err`;
  - the next accepted `i_start` clears `o_err`.
- **Zero frames**: `i_start` with `i_num_frames`=0 → `o_done` after one cycle, `o_buf_clear` never asserted, no pixels accepted.
